run_timeout_ctrl: RTL and testbench

RUN_TIMEOUT_CTRL -- requirements
Module: run_timeout_ctrl

---
 rtl/run_timeout_ctrl.sv | 153 +++++++++++++++
 tb/tb_run_timeout_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_timeout_ctrl.sv
// Run supervisor for an HLS kernel: starts a run, watches a per-attempt cycle budget,
// soft-resets the kernel on timeout or abort, retries a bounded number of times and reports status.
module run_timeout_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hEE6B_2800,
  parameter int unsigned MAX_RETRY      = 2,
  parameter int unsigned RST_CYCLES     = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        host_start,
  input  logic        host_abort,
  output logic        host_busy,
  output logic        host_done,
  output logic [1:0]  host_status,
  output logic [31:0] elapsed,
  output logic [2:0]  attempt,
  output logic        kernel_ap_start,
  input  logic        kernel_ap_ready,
  input  logic        kernel_ap_done,
  output logic        kernel_rst_n
);

  localparam int unsigned    RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0]  RST_LOAD  = RW'(RST_CYCLES - 1);
  localparam logic [2:0]     RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_FLUSH, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    STAT_OK      = 2'b00,
    STAT_TIMEOUT = 2'b01,
    STAT_ABORT   = 2'b10
  } status_t;

  state_t         state_q, state_d;
  status_t        status_q, status_d;
  status_t        pending_q, pending_d;
  logic [31:0]    timer_q, timer_d;
  logic [31:0]    elapsed_q, elapsed_d;
  logic [2:0]     attempt_q, attempt_d;
  logic [RW-1:0]  rst_cnt_q, rst_cnt_d;

  logic busy_q, done_q, ap_start_q, krst_n_q;
  logic active, expired;

  assign active  = (state_q == S_START) || (state_q == S_RUN);
  assign expired = (timer_q <= 32'd1);

  // NOTE: every signal written here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    elapsed_d = elapsed_q;
    attempt_d = attempt_q;
    rst_cnt_d = rst_cnt_q;

    if (active) begin
      timer_d = timer_q - 32'd1;
      if (elapsed_q != 32'hFFFF_FFFF) elapsed_d = elapsed_q + 32'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (host_start) begin
          state_d   = S_START;
          timer_d   = TIMEOUT_CYCLES;
          elapsed_d = 32'd0;
          attempt_d = 3'd0;
          status_d  = STAT_OK;
          pending_d = STAT_OK;
        end
      end
      S_START, S_RUN: begin
        // ap_done beats abort, abort beats expiry; in START, done only counts with ready
        if (kernel_ap_done && (state_q == S_RUN || kernel_ap_ready)) begin
          state_d  = S_DONE;
          status_d = STAT_OK;
        end else if (host_abort) begin
          state_d   = S_FLUSH;
          pending_d = STAT_ABORT;
          rst_cnt_d = RST_LOAD;
        end else if (expired) begin
          state_d   = S_FLUSH;
          pending_d = STAT_TIMEOUT;
          rst_cnt_d = RST_LOAD;
        end else if (state_q == S_START && kernel_ap_ready) begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (rst_cnt_q == '0) begin
          if (pending_q == STAT_TIMEOUT && attempt_q < RETRY_MAX) begin
            state_d   = S_START;
            attempt_d = attempt_q + 3'd1;
            timer_d   = TIMEOUT_CYCLES;
          end else begin
            state_d  = S_DONE;
            status_d = pending_q;
          end
        end else begin
          rst_cnt_d = rst_cnt_q - RW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      status_q   <= STAT_OK;
      pending_q  <= STAT_OK;
      timer_q    <= 32'd0;
      elapsed_q  <= 32'd0;
      attempt_q  <= 3'd0;
      rst_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ap_start_q <= 1'b0;
      krst_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      elapsed_q  <= elapsed_d;
      attempt_q  <= attempt_d;
      rst_cnt_q  <= rst_cnt_d;
      // Outputs are decoded from the next state so they line up with state_q.
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      ap_start_q <= (state_d == S_START);
      krst_n_q   <= (state_d != S_FLUSH);
    end
  end

  assign host_busy       = busy_q;
  assign host_done       = done_q;
  assign host_status     = status_q;
  assign elapsed         = elapsed_q;
  assign attempt         = attempt_q;
  assign kernel_ap_start = ap_start_q;
  assign kernel_rst_n    = krst_n_q;

endmodule

// File: tb/tb_run_timeout_ctrl.sv
// Directed bench for run_timeout_ctrl: instance A has a long budget for handshake and race
// cases, instance B uses TIMEOUT_CYCLES=8, MAX_RETRY=1, RST_CYCLES=4 for timeout/retry/reset cases.
module tb_run_timeout_ctrl;

  logic aclk;
  logic aresetn;

  logic        a_start, a_abort, a_ready, a_done;
  logic        a_busy, a_hdone, a_ap_start, a_krst_n;
  logic [1:0]  a_status;
  logic [31:0] a_elapsed;
  logic [2:0]  a_attempt;

  logic        b_start, b_abort, b_ready, b_done;
  logic        b_busy, b_hdone, b_ap_start, b_krst_n;
  logic [1:0]  b_status;
  logic [31:0] b_elapsed;
  logic [2:0]  b_attempt;

  int n_cmp = 0;
  int n_err = 0;
  int rst_low;

  run_timeout_ctrl #(
    .TIMEOUT_CYCLES(32'd100), .MAX_RETRY(2), .RST_CYCLES(4)
  ) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .host_start(a_start), .host_abort(a_abort),
    .host_busy(a_busy), .host_done(a_hdone), .host_status(a_status),
    .elapsed(a_elapsed), .attempt(a_attempt),
    .kernel_ap_start(a_ap_start), .kernel_ap_ready(a_ready),
    .kernel_ap_done(a_done), .kernel_rst_n(a_krst_n)
  );

  run_timeout_ctrl #(
    .TIMEOUT_CYCLES(32'd8), .MAX_RETRY(1), .RST_CYCLES(4)
  ) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .host_start(b_start), .host_abort(b_abort),
    .host_busy(b_busy), .host_done(b_hdone), .host_status(b_status),
    .elapsed(b_elapsed), .attempt(b_attempt),
    .kernel_ap_start(b_ap_start), .kernel_ap_ready(b_ready),
    .kernel_ap_done(b_done), .kernel_rst_n(b_krst_n)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    a_start = 0; a_abort = 0; a_ready = 0; a_done = 0;
    b_start = 0; b_abort = 0; b_ready = 0; b_done = 0;

    // Reset values
    repeat (2) @(posedge aclk);
    #1;
    check("rst_a_busy",     32'(a_busy), 0);
    check("rst_a_done",     32'(a_hdone), 0);
    check("rst_a_status",   32'(a_status), 0);
    check("rst_a_elapsed",  a_elapsed, 0);
    check("rst_a_attempt",  32'(a_attempt), 0);
    check("rst_a_ap_start", 32'(a_ap_start), 0);
    check("rst_a_krst_n",   32'(a_krst_n), 1);
    check("rst_b_krst_n",   32'(b_krst_n), 1);
    #3 aresetn = 1'b1;
    tick();

    // A: normal run, start@0 ready@3 done@10, extra start@5 ignored
    a_start = 1;
    tick();                                        // cycle 1
    a_start = 0;
    check("norm_ap_start_c1", 32'(a_ap_start), 1);
    check("norm_busy_c1",     32'(a_busy), 1);
    check("norm_elapsed_c1",  a_elapsed, 0);
    tick();                                        // cycle 2
    check("norm_ap_start_c2", 32'(a_ap_start), 1);
    tick();                                        // cycle 3
    a_ready = 1;
    check("norm_ap_start_c3", 32'(a_ap_start), 1);
    tick();                                        // cycle 4
    a_ready = 0;
    check("norm_ap_start_c4", 32'(a_ap_start), 0);
    check("norm_elapsed_c4",  a_elapsed, 3);
    tick();                                        // cycle 5
    a_start = 1;
    tick();                                        // cycle 6
    a_start = 0;
    check("busy_start_elapsed", a_elapsed, 5);
    check("busy_start_attempt", 32'(a_attempt), 0);
    check("busy_start_ap_start", 32'(a_ap_start), 0);
    repeat (4) tick();                             // cycle 10
    a_done = 1;
    check("norm_done_c10", 32'(a_hdone), 0);
    tick();                                        // cycle 11
    a_done = 0;
    check("norm_done_c11",    32'(a_hdone), 1);
    check("norm_status_c11",  32'(a_status), 0);
    check("norm_elapsed_c11", a_elapsed, 10);
    tick();                                        // cycle 12
    check("norm_done_c12",    32'(a_hdone), 0);
    check("norm_busy_c12",    32'(a_busy), 0);
    check("norm_elapsed_c12", a_elapsed, 10);

    // A: abort in RUN-less START at cycle 2 -> 4-cycle flush, status 10
    a_start = 1;
    tick();                                        // cycle 1
    a_start = 0;
    tick();                                        // cycle 2
    a_abort = 1;
    tick();                                        // cycle 3
    a_abort = 0;
    check("abort_krst_c3",     32'(a_krst_n), 0);
    check("abort_ap_start_c3", 32'(a_ap_start), 0);
    check("abort_busy_c3",     32'(a_busy), 1);
    repeat (3) tick();                             // cycle 6
    check("abort_krst_c6", 32'(a_krst_n), 0);
    tick();                                        // cycle 7
    check("abort_done_c7",    32'(a_hdone), 1);
    check("abort_status_c7",  32'(a_status), 2);
    check("abort_krst_c7",    32'(a_krst_n), 1);
    check("abort_elapsed_c7", a_elapsed, 2);
    tick();

    // A: ready and done together in START -> DONE next cycle
    a_start = 1;
    tick();                                        // cycle 1
    a_start = 0;
    check("rd_status_cleared", 32'(a_status), 0);
    check("rd_ap_start_c1",    32'(a_ap_start), 1);
    a_ready = 1; a_done = 1;
    tick();                                        // cycle 2
    a_ready = 0; a_done = 0;
    check("rd_done_c2",     32'(a_hdone), 1);
    check("rd_status_c2",   32'(a_status), 0);
    check("rd_ap_start_c2", 32'(a_ap_start), 0);
    check("rd_elapsed_c2",  a_elapsed, 1);
    tick();

    // A: ap_done and host_abort in the same RUN cycle -> done wins
    a_start = 1;
    tick();                                        // cycle 1
    a_start = 0;
    a_ready = 1;
    tick();                                        // cycle 2 (RUN)
    a_ready = 0;
    check("race_ap_start_c2", 32'(a_ap_start), 0);
    a_done = 1; a_abort = 1;
    tick();                                        // cycle 3
    a_done = 0; a_abort = 0;
    check("race_done_c3",    32'(a_hdone), 1);
    check("race_status_c3",  32'(a_status), 0);
    check("race_krst_c3",    32'(a_krst_n), 1);
    check("race_elapsed_c3", a_elapsed, 2);
    tick();

    // B: kernel never finishes -> two flushes, one retry, status 01, elapsed 16
    rst_low = 0;
    b_start = 1;
    for (int cyc = 1; cyc <= 26; cyc++) begin
      tick();
      b_start = (cyc == 5);
      if (b_krst_n == 1'b0) rst_low++;
      check("to_krst_n", 32'(b_krst_n),
            32'(!((cyc >= 9 && cyc <= 12) || (cyc >= 21 && cyc <= 24))));
      check("to_ap_start", 32'(b_ap_start),
            32'((cyc >= 1 && cyc <= 8) || (cyc >= 13 && cyc <= 20)));
      check("to_done", 32'(b_hdone), 32'(cyc == 25));
      if (cyc == 6) begin
        check("to_busy_start_elapsed", b_elapsed, 5);
        check("to_busy_start_attempt", 32'(b_attempt), 0);
      end
      if (cyc == 13) begin
        check("to_attempt_c13", 32'(b_attempt), 1);
        check("to_elapsed_c13", b_elapsed, 8);
      end
      if (cyc == 25) begin
        check("to_status_c25",  32'(b_status), 1);
        check("to_elapsed_c25", b_elapsed, 16);
        check("to_attempt_c25", 32'(b_attempt), 1);
      end
      if (cyc == 26) check("to_busy_c26", 32'(b_busy), 0);
    end
    check("to_rst_low_total", 32'(rst_low), 8);

    // B: abort on the expiry cycle -> status 10, no retry
    b_start = 1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick();
      b_start = 0;
      b_abort = (cyc == 8);
    end
    tick();                                        // cycle 9
    b_abort = 0;
    check("ae_krst_c9",   32'(b_krst_n), 0);
    check("ae_status_c9", 32'(b_status), 0);
    repeat (4) tick();                             // cycle 13
    check("ae_done_c13",     32'(b_hdone), 1);
    check("ae_status_c13",   32'(b_status), 2);
    check("ae_attempt_c13",  32'(b_attempt), 0);
    check("ae_ap_start_c13", 32'(b_ap_start), 0);
    tick();
    check("ae_busy_c14", 32'(b_busy), 0);

    // B: reset asserted mid-FLUSH, then a fresh start is accepted
    b_start = 1;
    tick();
    b_start = 0;
    repeat (8) tick();                             // cycle 9 (FLUSH)
    check("mr_krst_c9", 32'(b_krst_n), 0);
    #2 aresetn = 1'b0;
    #1;
    check("mr_krst_n",   32'(b_krst_n), 1);
    check("mr_busy",     32'(b_busy), 0);
    check("mr_ap_start", 32'(b_ap_start), 0);
    check("mr_elapsed",  b_elapsed, 0);
    check("mr_attempt",  32'(b_attempt), 0);
    check("mr_status",   32'(b_status), 0);
    check("mr_done",     32'(b_hdone), 0);
    #2 aresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mr_no_done", 32'(b_hdone), 0);
      check("mr_idle",    32'(b_busy), 0);
    end
    b_start = 1;
    tick();
    b_start = 0;
    check("mr_restart_ap_start", 32'(b_ap_start), 1);
    check("mr_restart_busy",     32'(b_busy), 1);
    check("mr_restart_elapsed",  b_elapsed, 0);
    check("mr_restart_attempt",  32'(b_attempt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
